// File: rtl/md_unit_if.sv
// Handshake and write-back bundle between the register bank and the
// iterative multiply/divide unit.
interface md_unit_if #(
   parameter int W = 32
);
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [1:0]   EW;
   logic         DF;

   modport master (
      output start, op, A, B,
      input  busy, done, result, EW, DF
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, result, EW, DF
   );
endinterface

// File: rtl/md_unit.sv
// Iterative unsigned MUL/MULH/DIVU/REMU: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, single-cycle registered write-back.
module md_unit #(
   parameter int W = 32
) (
   input logic clk,
   input logic rst,
   md_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   res_q, res_d;
   logic [1:0]     ew_q, ew_d;
   logic           df_q, df_d;
   logic           done_q, done_d;

   logic [W:0]     msum;
   logic [W+1:0]   diff;
   logic [2*W-1:0] step;

   // acc holds {hi, lo}: hi = partial product / remainder,
   // lo = multiplier / dividend shifting out as quotient shifts in
   always_comb begin
      msum = {1'b0, acc_q[2*W-1:W]}
           + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      diff = {1'b0, acc_q[2*W-1:W-1]} - {2'b00, opnd_q};
      if (op_q[1]) begin
         if (diff[W+1])
            step = {acc_q[2*W-2:0], 1'b0};
         else
            step = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
         step = {msum, acc_q[W-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      res_d   = res_q;
      ew_d    = 2'b00;
      df_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d   = bus.op;
               cnt_d  = 6'd0;
               opnd_d = bus.op[1] ? bus.B : bus.A;
               acc_d  = {{W{1'b0}}, (bus.op[1] ? bus.A : bus.B)};
               if (bus.op[1] && (bus.B == '0)) begin
                  state_d = DONE;
                  res_d   = '1;
                  ew_d    = 2'b01;
                  df_d    = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(W - 1)) begin
               state_d = DONE;
               res_d   = op_q[0] ? step[2*W-1:W] : step[W-1:0];
               ew_d    = 2'b11;
               done_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         ew_q    <= 2'b00;
         df_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         ew_q    <= ew_d;
         df_q    <= df_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.EW     = ew_q;
   assign bus.DF     = df_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, randomized ops
// against an arithmetic reference, async reset abort and held-start cases.
module tb_md_unit;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   md_unit_if #(.W(32)) bus ();

   md_unit #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [1:0]  ew;
      logic        df;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit product and integer divide/modulo
   function automatic void model(input logic [1:0] o,
                                 input logic [31:0] a, b,
                                 output logic [31:0] r,
                                 output logic [1:0] ew,
                                 output logic df);
      logic [63:0] p;
      p  = {32'd0, a} * {32'd0, b};
      ew = 2'b11;
      df = 1'b0;
      case (o)
         2'd0: r = p[31:0];
         2'd1: r = p[63:32];
         default: begin
            if (b == 0) begin
               r  = 32'hFFFF_FFFF;
               ew = 2'b01;
               df = 1'b1;
            end else begin
               r = (o == 2'd2) ? a / b : a % b;
            end
         end
      endcase
   endfunction

   // lat = posedges after the accepting edge before done is seen;
   // normal ops reach DONE 32 edges later, div-by-zero right after accept
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, b,
                         output logic [31:0] r, output logic [1:0] ew,
                         output logic df, output int lat);
      @(negedge clk);
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.op    = 2'($urandom);
      lat = -1;
      r   = '0;
      ew  = '0;
      df  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            lat = i;
            r   = bus.result;
            ew  = bus.EW;
            df  = bus.DF;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("pulse_end_done_busy", {bus.done, bus.busy, bus.EW}, 64'd0);
   endtask

   task automatic check_op(input string tag, input logic [1:0] o,
                           input logic [31:0] a, b,
                           input logic [31:0] er, input logic [1:0] eew,
                           input logic edf);
      logic [31:0] r;
      logic [1:0]  ew;
      logic        df;
      int          lat;
      run_op(o, a, b, r, ew, df, lat);
      chk({tag, "_result"}, r, er);
      chk({tag, "_ew"}, ew, eew);
      chk({tag, "_df"}, df, edf);
      chk({tag, "_latency"}, lat, (eew == 2'b01) ? 0 : 32);
   endtask

   vec_t vt[10];

   initial begin
      logic [31:0] er;
      logic [1:0]  eew;
      logic        edf;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  ro;
      logic [31:0] av[102];
      logic [31:0] bv[102];
      int          pulses;
      int          seen;

      n_cmp = 0;
      n_err = 0;
      clk = 0;
      rst = 1;
      bus.start = 0;
      bus.op = 0;
      bus.A = 0;
      bus.B = 0;

      vt[0] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2'b11, 1'b0};
      vt[1] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2'b11, 1'b0};
      vt[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 1'b0};
      vt[3] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b11, 1'b0};
      vt[4] = '{2'd2, 32'd100, 32'd7, 32'd14, 2'b11, 1'b0};
      vt[5] = '{2'd3, 32'd100, 32'd7, 32'd2, 2'b11, 1'b0};
      vt[6] = '{2'd2, 32'd5, 32'd9, 32'd0, 2'b11, 1'b0};
      vt[7] = '{2'd3, 32'd5, 32'd9, 32'd5, 2'b11, 1'b0};
      vt[8] = '{2'd2, 32'd123, 32'd0, 32'hFFFF_FFFF, 2'b01, 1'b1};
      vt[9] = '{2'd3, 32'hFFFF_FFFF, 32'h1, 32'd0, 2'b11, 1'b0};

      #1;
      chk("reset_outputs",
          {bus.busy, bus.done, bus.EW, bus.DF, bus.result}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 10; i++)
         check_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                  vt[i].res, vt[i].ew, vt[i].df);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         model(ro, ra, rb, er, eew, edf);
         check_op($sformatf("rnd%0d", i), ro, ra, rb, er, eew, edf);
      end

      // async reset in the middle of RUN: immediate clear, no write-back
      @(negedge clk);
      bus.op = 2'd0;
      bus.A = 32'h1234_5678;
      bus.B = 32'h9ABC_DEF0;
      bus.start = 1;
      @(posedge clk);
      #1;
      bus.start = 0;
      repeat (10) @(posedge clk);
      #3;
      rst = 1;
      #1;
      chk("rst_mid_run_outputs",
          {bus.busy, bus.done, bus.EW, bus.DF, bus.result}, 64'd0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.EW != 2'b00) seen++;
      end
      chk("rst_mid_run_no_writeback", seen, 0);
      model(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, er, eew, edf);
      check_op("after_rst", 2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, er, eew, edf);

      // start held high with operands changing every cycle: accepts
      // at edges 0, 34, 68 -> done visible after edges 32, 66, 100
      pulses = 0;
      @(negedge clk);
      for (int i = 0; i < 102; i++) begin
         av[i] = $urandom;
         bv[i] = $urandom | 32'd1;
         bus.op = 2'd2;
         bus.A = av[i];
         bus.B = bv[i];
         bus.start = (i <= 100);
         @(posedge clk);
         #1;
         if (bus.done) begin
            chk($sformatf("held_pulse%0d_edge", pulses), i, 32 + 34 * pulses);
            model(2'd2, av[34 * (pulses % 3)], bv[34 * (pulses % 3)],
                  er, eew, edf);
            chk($sformatf("held_pulse%0d_result", pulses), bus.result, er);
            pulses++;
         end
         @(negedge clk);
      end
      bus.start = 0;
      chk("held_pulse_count", pulses, 3);
      chk("held_final_idle", bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
